// File: rtl/addsub_multicycle.sv
// Multi-cycle adder/subtractor: one SLICE-bit lookahead slice per clock, LSB slice first,
// with the inter-slice carry held in a register. Start/done handshake.
module addsub_multicycle #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0]    LastIdx   = IW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SliceMask = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, s_q, s_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             sub_q, sub_d, carry_q, carry_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             co_q, co_d, ov_q, ov_d, zero_q, zero_d;

    logic [31:0]      base;
    logic [SLICE-1:0] slice_a, slice_b, slice_sum;
    logic             slice_co, msb_ci;
    logic [WIDTH-1:0] s_wr;

    assign base = 32'(idx_q) * 32'(SLICE);

    // Current slice of the operands, B conditionally inverted for subtraction.
    always_comb begin
        slice_a = SLICE'(op_a_q >> base);
        slice_b = SLICE'(op_b_q >> base) ^ {SLICE{sub_q}};
        {slice_co, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from its sum bit; only used on the last slice.
        msb_ci = slice_sum[SLICE-1] ^ slice_a[SLICE-1] ^ slice_b[SLICE-1];
        s_wr   = (s_q & ~(SliceMask << base)) | (WIDTH'(slice_sum) << base);
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;
        zero_d  = zero_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            StRun: begin
                s_d     = s_wr;
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                busy_d  = 1'b1;
                if (idx_q == LastIdx) begin
                    co_d    = slice_co;
                    ov_d    = msb_ci ^ slice_co;
                    zero_d  = (s_wr == '0);
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    sub_d   = sub;
                    carry_d = sub;
                    idx_d   = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
                    ov_d    = 1'b0;
                    zero_d  = 1'b0;
                    state_d = StRun;
                    busy_d  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;
    assign ov   = ov_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Bench for addsub_multicycle: three configurations (32/16, 16/4, 8/8) driven from shared
// inputs and checked against a whole-word arithmetic reference model.
module tb_addsub_multicycle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;

    logic        busy32, done32, co32, ov32, z32;
    logic [31:0] s32;
    logic        busy16, done16, co16, ov16, z16;
    logic [15:0] s16;
    logic        busy8, done8, co8, ov8, z8;
    logic [7:0]  s8;

    int n_tests = 0;
    int n_fail  = 0;

    int          wid[3] = '{32, 16, 8};
    int          nsl[3] = '{2, 4, 1};
    int          lat[3];
    int          npulse[3];
    logic [31:0] cs[3];
    logic        cco[3], cov[3], cz[3];

    always #5 clk = ~clk;

    addsub_multicycle #(.WIDTH(32), .SLICE(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in), .b(b_in),
        .busy(busy32), .done(done32), .s(s32), .co(co32), .ov(ov32), .zero(z32)
    );
    addsub_multicycle #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in[15:0]), .b(b_in[15:0]),
        .busy(busy16), .done(done16), .s(s16), .co(co16), .ov(ov16), .zero(z16)
    );
    addsub_multicycle #(.WIDTH(8), .SLICE(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a_in[7:0]), .b(b_in[7:0]),
        .busy(busy8), .done(done8), .s(s8), .co(co8), .ov(ov8), .zero(z8)
    );

    // Reference: w-bit A + (sub ? ~B : B) + sub; signed overflow from operand/result signs.
    function automatic void model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                  input logic sv, output logic [31:0] es, output logic eco,
                                  output logic eov, output logic ez);
        logic [31:0] mask, am, bm;
        logic [32:0] full;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am   = av & mask;
        bm   = (sv ? ~bv : bv) & mask;
        full = {1'b0, am} + {1'b0, bm} + {32'd0, sv};
        es   = full[31:0] & mask;
        eco  = full[w];
        if (sv) eov = (av[w-1] != bv[w-1]) && (es[w-1] != av[w-1]);
        else    eov = (av[w-1] == bv[w-1]) && (es[w-1] != av[w-1]);
        ez   = (es == 32'd0);
    endfunction

    function automatic void peek(input int i, output logic d, output logic [31:0] sx,
                                 output logic c, output logic o, output logic z);
        case (i)
            0:       begin d = done32; sx = s32;          c = co32; o = ov32; z = z32; end
            1:       begin d = done16; sx = {16'd0, s16}; c = co16; o = ov16; z = z16; end
            default: begin d = done8;  sx = {24'd0, s8};  c = co8;  o = ov8;  z = z8;  end
        endcase
    endfunction

    // Issue one request to all three DUTs and record each one's first done pulse.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        logic d, c, o, z;
        logic [31:0] sx;
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            npulse[i] = 0;
        end
        @(negedge clk);
        start = 1'b1; a_in = av; b_in = bv; sub = sv;
        @(negedge clk);
        start = 1'b0; a_in = $urandom; b_in = $urandom; sub = 1'($urandom_range(0, 1));
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                peek(i, d, sx, c, o, z);
                if (d) begin
                    npulse[i]++;
                    if (lat[i] == 0) begin
                        lat[i] = cyc; cs[i] = sx; cco[i] = c; cov[i] = o; cz[i] = z;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy32, done32, s32, co32, ov32, z32} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset32: got busy=%b done=%b s=%h co=%b ov=%b z=%b, expected all 0",
                     busy32, done32, s32, co32, ov32, z32);
        end
        n_tests++;
        if ({busy16, done16, s16, co16, ov16, z16} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset16: got s=%h busy=%b done=%b, expected all 0", s16, busy16, done16);
        end
        n_tests++;
        if ({busy8, done8, s8, co8, ov8, z8} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset8: got s=%h busy=%b done=%b, expected all 0", s8, busy8, done8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] va[7] = '{32'h0000FFFF, 32'd5, 32'h12345678, 32'h7FFFFFFF, 32'h80000000,
                               32'h00000FFF, 32'h000000FF};
        logic [31:0] vb[7] = '{32'd1, 32'd7, 32'h12345678, 32'd1, 32'd1, 32'd1, 32'd1};
        logic        vs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] xs[7] = '{32'h00010000, 32'hFFFFFFFE, 32'h0, 32'h80000000, 32'h7FFFFFFF,
                               32'h00001000, 32'h00000100};
        logic [2:0]  xf[7] = '{3'b000, 3'b000, 3'b101, 3'b010, 3'b110, 3'b000, 3'b000};
        logic [31:0] es;
        logic        eco, eov, ez;
        for (int v = 0; v < 7; v++) begin
            do_op(va[v], vb[v], vs[v]);
            n_tests++;
            if ({cs[0], cco[0], cov[0], cz[0]} !== {xs[v], xf[v]} || lat[0] != 2
                || npulse[0] != 1) begin
                n_fail++;
                $display("FAIL directed32 #%0d: got s=%h co/ov/z=%b%b%b lat=%0d pulses=%0d, expected s=%h co/ov/z=%b lat=2 pulses=1",
                         v, cs[0], cco[0], cov[0], cz[0], lat[0], npulse[0], xs[v], xf[v]);
            end
            for (int i = 1; i < 3; i++) begin
                model(wid[i], va[v], vb[v], vs[v], es, eco, eov, ez);
                n_tests++;
                if ({cs[i], cco[i], cov[i], cz[i]} !== {es, eco, eov, ez} || lat[i] != nsl[i]
                    || npulse[i] != 1) begin
                    n_fail++;
                    $display("FAIL directed w%0d #%0d: got s=%h co/ov/z=%b%b%b lat=%0d, expected s=%h co/ov/z=%b%b%b lat=%0d",
                             wid[i], v, cs[i], cco[i], cov[i], cz[i], lat[i], es, eco, eov, ez,
                             nsl[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] av, bv, es;
        logic        sv, eco, eov, ez;
        for (int n = 0; n < 25; n++) begin
            av = $urandom;
            bv = ($urandom_range(0, 4) == 0) ? av : $urandom;
            sv = 1'($urandom_range(0, 1));
            do_op(av, bv, sv);
            for (int i = 0; i < 3; i++) begin
                model(wid[i], av, bv, sv, es, eco, eov, ez);
                n_tests++;
                if ({cs[i], cco[i], cov[i], cz[i]} !== {es, eco, eov, ez} || lat[i] != nsl[i]
                    || npulse[i] != 1) begin
                    n_fail++;
                    $display("FAIL random w%0d a=%h b=%h sub=%b: got s=%h co/ov/z=%b%b%b lat=%0d pulses=%0d, expected s=%h co/ov/z=%b%b%b lat=%0d",
                             wid[i], av, bv, sv, cs[i], cco[i], cov[i], cz[i], lat[i],
                             npulse[i], es, eco, eov, ez, nsl[i]);
                end
            end
            model(32, av, bv, sv, es, eco, eov, ez);
            n_tests++;
            if (s32 !== es || busy32 !== 1'b0) begin
                n_fail++;
                $display("FAIL hold32: got s=%h busy=%b in idle, expected s=%h busy=0",
                         s32, busy32, es);
            end
        end
    endtask

    // start held high: only DONE-cycle starts are accepted, RUN-cycle operand changes ignored.
    task automatic test_back_to_back();
        logic [31:0] ca, cb, es;
        logic        csub, eco, eov, ez, found;
        int          bc;
        @(negedge clk);
        ca = $urandom; cb = $urandom; csub = 1'($urandom_range(0, 1));
        start = 1'b1; a_in = ca; b_in = cb; sub = csub;
        for (int r = 0; r < 6; r++) begin
            found = 1'b0;
            bc = 0;
            for (int c = 0; c < 10 && !found; c++) begin
                @(negedge clk);
                if (done32) found = 1'b1;
                else if (busy32) begin
                    bc++;
                    a_in = $urandom; b_in = $urandom; sub = 1'($urandom_range(0, 1));
                end
            end
            model(32, ca, cb, csub, es, eco, eov, ez);
            n_tests++;
            if (!found || {s32, co32, ov32, z32} !== {es, eco, eov, ez} || bc != 2) begin
                n_fail++;
                $display("FAIL back_to_back #%0d: got done=%b s=%h co/ov/z=%b%b%b busy_cycles=%0d, expected done=1 s=%h co/ov/z=%b%b%b busy_cycles=2",
                         r, found, s32, co32, ov32, z32, bc, es, eco, eov, ez);
            end
            ca = $urandom; cb = $urandom; csub = 1'($urandom_range(0, 1));
            a_in = ca; b_in = cb; sub = csub;
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] av, bv, es;
        logic        sv, eco, eov, ez, saw;
        @(negedge clk);
        start = 1'b1; a_in = 32'h0000_1234; b_in = 32'd1; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy32, done32, s32, co32, ov32, z32} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b s=%h co=%b ov=%b z=%b, expected all 0",
                     busy32, done32, s32, co32, ov32, z32);
        end
        saw = 1'b0;
        repeat (2) @(negedge clk) if (done32) saw = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk) if (done32 || busy32) saw = 1'b1;
        n_tests++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got done/busy activity=%b after abort, expected 0", saw);
        end
        av = $urandom; bv = $urandom; sv = 1'($urandom_range(0, 1));
        do_op(av, bv, sv);
        model(32, av, bv, sv, es, eco, eov, ez);
        n_tests++;
        if ({cs[0], cco[0], cov[0], cz[0]} !== {es, eco, eov, ez} || lat[0] != 2) begin
            n_fail++;
            $display("FAIL after_reset: got s=%h co/ov/z=%b%b%b lat=%0d, expected s=%h co/ov/z=%b%b%b lat=2",
                     cs[0], cco[0], cov[0], cz[0], lat[0], es, eco, eov, ez);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
